// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial binary-to-BCD converter:
//   state_e        - converter FSM encoding (IDLE = 0, SHIFT = 1)
//   BCD_W          - width of one BCD digit
//   ADD3_THRESHOLD - digit value at or above which the double-dabble +3 applies
//   ADD3_VALUE     - correction added to such a digit before the shift
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int               BCD_W          = 4;
    localparam logic [BCD_W-1:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [BCD_W-1:0] ADD3_VALUE     = 4'd3;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational double-dabble correction cell for one BCD digit: a digit of 5
// or more gets +3 so that the following left shift carries correctly into the
// next digit. The sum is 4 bits wide; the carry-out is dropped because a legal
// digit (0..9) never pushes the result past 12.
//
// Ports:
//   digit_i - BCD scratch digit before correction
//   digit_o - corrected digit, ready to be shifted
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit_i,
    output logic [BCD_W-1:0] digit_o
);

    assign digit_o = (digit_i >= ADD3_THRESHOLD) ? digit_i + ADD3_VALUE : digit_i;

endmodule : bcd_digit_adjust

// File: rtl/bcd_serial_converter.sv
// -----------------------------------------------------------------------------
// bcd_serial_converter
// Serial (one bit per clock) binary-to-BCD converter using the double-dabble
// algorithm. A start seen in IDLE loads num; WIDTH SHIFT cycles follow; on the
// last one the converted digits are written to the output registers and done
// pulses for one cycle while the FSM is already back in IDLE, so a start in
// the done cycle is accepted and conversions can run back to back every
// WIDTH+1 cycles.
//
// Parameters:
//   WIDTH  - binary input width
//   DIGITS - number of BCD digits in the scratch register
//
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - conversion request, honoured only in IDLE
//   num       - unsigned binary value, captured when start is accepted
//   busy      - high while a conversion is in progress
//   done      - one-cycle pulse: new digit outputs are valid
//   thousands - registered BCD digit 3
//   hundreds  - registered BCD digit 2
//   tens      - registered BCD digit 1
//   ones      - registered BCD digit 0
// -----------------------------------------------------------------------------
module bcd_serial_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int CNT_W      = $clog2(WIDTH + 1);
    localparam int SCR_W      = DIGITS * BCD_W;
    localparam int OUT_DIGITS = 4;
    localparam int OUT_W      = OUT_DIGITS * BCD_W;
    // Scratch view widened so the four output digits always exist, even when
    // DIGITS is configured below four.
    localparam int PAD_DIGITS = (DIGITS > OUT_DIGITS) ? DIGITS : OUT_DIGITS;
    localparam int PAD_W      = PAD_DIGITS * BCD_W;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   bin_q,     bin_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               done_q,    done_d;
    logic [OUT_W-1:0]   digits_q,  digits_d;

    // -------------------------------------------------------------------------
    // Double-dabble datapath: correct every digit, then shift {scratch, bin}
    // -------------------------------------------------------------------------
    logic [SCR_W-1:0] scratch_adj;
    logic [SCR_W-1:0] scratch_shift;
    logic [WIDTH-1:0] bin_shift;
    logic [PAD_W-1:0] scratch_pad;
    logic             adj_msb_unused;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .digit_i (scratch_q[g*BCD_W +: BCD_W]),
            .digit_o (scratch_adj[g*BCD_W +: BCD_W])
        );
    end

    // The top scratch bit leaves on the shift; it can only be set when the
    // input exceeds what DIGITS decimal digits can hold.
    assign adj_msb_unused = scratch_adj[SCR_W-1];
    assign {scratch_shift, bin_shift} = {scratch_adj[SCR_W-2:0], bin_q, 1'b0};
    assign scratch_pad = PAD_W'(scratch_shift);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets its hold value first so no path through the case
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        digits_d  = digits_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = num;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                bin_d     = bin_shift;
                scratch_d = scratch_shift;
                cnt_d     = cnt_q + CNT_W'(1);
                // Final shift: publish the just-shifted digits on this edge so
                // done and the new outputs appear together, with busy already low.
                if (cnt_q == LAST_CNT) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    digits_d = scratch_pad[OUT_W-1:0];
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the reset clears all of them, which is also what aborts a conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            digits_q  <= '0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            digits_q  <= digits_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign thousands = digits_q[3*BCD_W +: BCD_W];
    assign hundreds  = digits_q[2*BCD_W +: BCD_W];
    assign tens      = digits_q[1*BCD_W +: BCD_W];
    assign ones      = digits_q[0*BCD_W +: BCD_W];

endmodule : bcd_serial_converter
